// File: rtl/fragment_hazard_scheduler.sv
// fragment_hazard_scheduler
//
// Purpose: an in-order fragment scheduler that sits in front of the
// per-fragment pipeline. It forwards fragments through a single registered
// output stage and keeps the framebuffer index of every fragment that has
// been issued but not yet written back. An incoming fragment whose index
// matches an in-flight entry is held off until that entry retires. This
// keeps read-after-write hazards off the color, depth and stencil buffers.
// A flush request drains every in-flight fragment and then pulses
// flushDone, so a framebuffer commit can follow.
//
// Ports:
//   aclk, resetn                  clock and asynchronous active-low reset
//   s_frag_*                      upstream fragment channel (valid/ready)
//   m_frag_*                      downstream fragment channel, registered
//   wb_valid, wb_index            write-back observed from the pipeline;
//                                 retires the oldest in-flight entry
//   flush                         drain request (level), sampled in RUN
//   flushDone                     one-cycle pulse when the drain completes
//   busy                          scoreboard non-empty or output stage full
//   protocolError                 sticky; cleared only by reset
//   stallCycles                   hazard stall counter
//
// Build option: define FRAGMENT_HAZARD_STATS_EN to compile the saturating
// hazard stall counter. Without it, stallCycles is tied to zero.
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal forwarding; flush moves to ST_DRAIN
//   ST_DRAIN | no new fragments; wait for empty scoreboard and output
//   ST_DONE  | flushDone pulse for one cycle, then back to ST_RUN

module fragment_hazard_scheduler #(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int PAYLOAD_WIDTH           = 112,
  parameter int ENTRIES                 = 8
) (
  input  logic                               aclk,
  input  logic                               resetn,
  input  logic                               s_frag_tvalid,
  output logic                               s_frag_tready,
  input  logic                               s_frag_tlast,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
  input  logic [PAYLOAD_WIDTH-1:0]           s_frag_tpayload,
  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic                               m_frag_tlast,
  output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
  output logic [PAYLOAD_WIDTH-1:0]           m_frag_tpayload,
  input  logic                               wb_valid,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] wb_index,
  input  logic                               flush,
  output logic                               flushDone,
  output logic                               busy,
  output logic                               protocolError,
  output logic [31:0]                        stallCycles
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] sb_idx_q [ENTRIES];
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] sb_idx_d [ENTRIES];
  logic [PTR_W-1:0]                   head_q, head_d;
  logic [PTR_W-1:0]                   tail_q, tail_d;
  logic [CNT_W-1:0]                   count_q, count_d;

  logic                               m_valid_q, m_valid_d;
  logic                               m_last_q, m_last_d;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index_q, m_index_d;
  logic [PAYLOAD_WIDTH-1:0]           m_payload_q, m_payload_d;

  logic                               prot_err_q, prot_err_d;

  logic in_run;
  logic hit;
  logic full;
  logic out_free;
  logic accept;
  logic retire;
  logic wb_err;

  // ---------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((count_q == '0) && !m_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    in_run    = (state_q == ST_RUN);
    flushDone = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------
  // Hazard detection. Slot i is live when its distance from the head is
  // below count. Pointer arithmetic wraps because ENTRIES is a power of
  // two. A slot retiring this cycle is still live, so no bypass happens.
  // ---------------------------------------------------------------------
  always_comb begin
    logic [PTR_W-1:0] offset;
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      offset = PTR_W'(i) - head_q;
      if ((CNT_W'(offset) < count_q) && (sb_idx_q[i] == s_frag_tindex)) begin
        hit = 1'b1;
      end
    end
  end

  // Full ignores a same-cycle retire, which keeps ready off the wb path.
  // resetn gates ready so that it reads low for the whole reset window.
  always_comb begin
    full          = (count_q == CNT_W'(ENTRIES));
    out_free      = !m_valid_q || m_frag_tready;
    s_frag_tready = resetn && in_run && out_free && !full && !hit;
    accept        = s_frag_tvalid && s_frag_tready;
    retire        = wb_valid && (count_q != '0);
    wb_err        = wb_valid && ((count_q == '0) || (sb_idx_q[head_q] != wb_index));
  end

  // ---------------------------------------------------------------------
  // Scoreboard FIFO
  // ---------------------------------------------------------------------
  always_comb begin
    sb_idx_d = sb_idx_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (accept) begin
      sb_idx_d[tail_q] = s_frag_tindex;
      tail_d           = tail_q + PTR_W'(1);
    end
    if (retire) begin
      head_d = head_q + PTR_W'(1);
    end
    if (accept && !retire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && retire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Output stage. It loads on every accept. Because accept requires
  // out_free, the data stays stable while the stage is stalled.
  // ---------------------------------------------------------------------
  always_comb begin
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_index_d   = m_index_q;
    m_payload_d = m_payload_q;
    if (accept) begin
      m_valid_d   = 1'b1;
      m_last_d    = s_frag_tlast;
      m_index_d   = s_frag_tindex;
      m_payload_d = s_frag_tpayload;
    end else if (m_frag_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    prot_err_d = prot_err_q || wb_err;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      sb_idx_q    <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_index_q   <= '0;
      m_payload_q <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      sb_idx_q    <= sb_idx_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_index_q   <= m_index_d;
      m_payload_q <= m_payload_d;
      prot_err_q  <= prot_err_d;
    end
  end

  always_comb begin
    m_frag_tvalid   = m_valid_q;
    m_frag_tlast    = m_last_q;
    m_frag_tindex   = m_index_q;
    m_frag_tpayload = m_payload_q;
    busy            = (count_q != '0) || m_valid_q;
    protocolError   = prot_err_q;
  end

  // ---------------------------------------------------------------------
  // Hazard stall statistics
  // ---------------------------------------------------------------------
`ifdef FRAGMENT_HAZARD_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_run && s_frag_tvalid && hit && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stallCycles = stall_q;
`else
  assign stallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_fragment_hazard_scheduler.sv
module tb_fragment_hazard_scheduler;

  localparam int IW      = 14;
  localparam int PW      = 112;
  localparam int ENTRIES = 8;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  typedef struct {
    logic [IW-1:0] idx;
    logic [PW-1:0] pl;
    logic          last;
  } frag_t;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          s_frag_tvalid, s_frag_tready, s_frag_tlast;
  logic [IW-1:0] s_frag_tindex;
  logic [PW-1:0] s_frag_tpayload;
  logic          m_frag_tvalid, m_frag_tready, m_frag_tlast;
  logic [IW-1:0] m_frag_tindex;
  logic [PW-1:0] m_frag_tpayload;
  logic          wb_valid;
  logic [IW-1:0] wb_index;
  logic          flush, flushDone, busy, protocolError;
  logic [31:0]   stallCycles;

  int total = 0;
  int bad   = 0;

  // reference model
  frag_t         exp_q[$];
  logic [IW-1:0] inflight[$];
  bit            out_full = 0;
  int            mode = M_RUN;
  bit            err = 0;
  logic [31:0]   stall = 0;
  bit            acc_last = 0;

  fragment_hazard_scheduler #(
    .FRAMEBUFFER_INDEX_WIDTH(IW),
    .PAYLOAD_WIDTH(PW),
    .ENTRIES(ENTRIES)
  ) dut (
    .aclk(aclk),
    .resetn(resetn),
    .s_frag_tvalid(s_frag_tvalid),
    .s_frag_tready(s_frag_tready),
    .s_frag_tlast(s_frag_tlast),
    .s_frag_tindex(s_frag_tindex),
    .s_frag_tpayload(s_frag_tpayload),
    .m_frag_tvalid(m_frag_tvalid),
    .m_frag_tready(m_frag_tready),
    .m_frag_tlast(m_frag_tlast),
    .m_frag_tindex(m_frag_tindex),
    .m_frag_tpayload(m_frag_tpayload),
    .wb_valid(wb_valid),
    .wb_index(wb_index),
    .flush(flush),
    .flushDone(flushDone),
    .busy(busy),
    .protocolError(protocolError),
    .stallCycles(stallCycles)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef FRAGMENT_HAZARD_STATS_EN
    return stall;
`else
    return 32'd0;
`endif
  endfunction

  // Model: evaluates the spec rules each cycle on stable inputs (negedge),
  // compares the DUT's control outputs, then advances to the next cycle.
  always @(negedge aclk) begin
    bit hit, rdy, acc, empty_now;
    if (!resetn) begin
      chk("rst_s_frag_tready", s_frag_tready, 0);
      chk("rst_m_frag_tvalid", m_frag_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flushDone", flushDone, 0);
      chk("rst_protocolError", protocolError, 0);
      chk("rst_stallCycles", stallCycles, 0);
      exp_q.delete();
      inflight.delete();
      out_full = 0;
      mode     = M_RUN;
      err      = 0;
      stall    = 0;
      acc_last = 0;
    end else begin
      hit = 0;
      foreach (inflight[i]) if (inflight[i] == s_frag_tindex) hit = 1;
      rdy = (mode == M_RUN) && (!out_full || m_frag_tready) &&
            (inflight.size() < ENTRIES) && !hit;
      chk("s_frag_tready", s_frag_tready, rdy);
      chk("m_frag_tvalid", m_frag_tvalid, out_full);
      chk("busy", busy, (inflight.size() != 0) || out_full);
      chk("flushDone", flushDone, mode == M_DONE);
      chk("protocolError", protocolError, err);
      chk("stallCycles", stallCycles, exp_stall());

      acc       = s_frag_tvalid && rdy;
      acc_last  = acc;
      empty_now = (inflight.size() == 0) && !out_full;
      if ((mode == M_RUN) && s_frag_tvalid && hit && (stall != 32'hFFFF_FFFF)) stall++;

      case (mode)
        M_RUN:   if (flush) mode = M_DRAIN;
        M_DRAIN: if (empty_now) mode = M_DONE;
        default: mode = M_RUN;
      endcase

      if (wb_valid) begin
        if (inflight.size() == 0) err = 1;
        else begin
          if (wb_index != inflight[0]) err = 1;
          void'(inflight.pop_front());
        end
      end
      if (acc) begin
        frag_t f;
        f.idx  = s_frag_tindex;
        f.pl   = s_frag_tpayload;
        f.last = s_frag_tlast;
        exp_q.push_back(f);
        inflight.push_back(s_frag_tindex);
        out_full = 1;
      end else if (m_frag_tready) begin
        out_full = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands a fragment downstream.
  always @(negedge aclk) begin
    if (resetn && m_frag_tvalid && m_frag_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        frag_t e;
        e = exp_q.pop_front();
        chk("m_frag_tindex", m_frag_tindex, e.idx);
        chk("m_frag_tpayload", m_frag_tpayload, e.pl);
        chk("m_frag_tlast", m_frag_tlast, e.last);
      end
    end
  end

  // One stimulus cycle; percentages in 0..100.
  task automatic drive(input int idx_max, input int p_valid, input int p_ready,
                       input int p_wb, input int p_flush, input int p_err);
    @(posedge aclk);
    #1;
    if (!(s_frag_tvalid && !acc_last)) begin
      s_frag_tvalid   = ($urandom_range(0, 99) < p_valid);
      s_frag_tindex   = IW'($urandom_range(0, idx_max));
      s_frag_tpayload = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
      s_frag_tlast    = ($urandom_range(0, 7) == 0);
    end
    m_frag_tready = ($urandom_range(0, 99) < p_ready);
    flush         = ($urandom_range(0, 99) < p_flush);
    wb_valid      = 1'b0;
    wb_index      = '0;
    if ($urandom_range(0, 99) < p_err) begin
      wb_valid = 1'b1;
      wb_index = IW'($urandom());
    end else if ((inflight.size() != 0) && ($urandom_range(0, 99) < p_wb)) begin
      wb_valid = 1'b1;
      wb_index = inflight[0];
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge aclk);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_m_frag_tvalid", m_frag_tvalid, 0);
    chk("async_busy", busy, 0);
    chk("async_s_frag_tready", s_frag_tready, 0);
    chk("async_protocolError", protocolError, 0);
    repeat (cycles) @(posedge aclk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn          = 1'b0;
    s_frag_tvalid   = 1'b0;
    s_frag_tlast    = 1'b0;
    s_frag_tindex   = '0;
    s_frag_tpayload = '0;
    m_frag_tready   = 1'b0;
    wb_valid        = 1'b0;
    wb_index        = '0;
    flush           = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    resetn = 1'b1;

    // dense hazards, frequent write-backs, occasional flush
    repeat (400) drive(15, 80, 75, 45, 3, 0);
    // sparse hazards, rare write-backs so the scoreboard fills
    repeat (200) drive(4095, 90, 90, 10, 0, 0);
    // mid-stream reset with entries in flight
    pulse_reset(2);
    // post-reset stream with flushes
    repeat (300) drive(7, 70, 85, 50, 5, 0);
    // protocol errors: stray and mismatched write-backs
    repeat (150) drive(31, 60, 80, 30, 2, 8);
    pulse_reset(1);
    // full-throughput stream with flushes, then a clean drain
    repeat (300) drive(1023, 100, 100, 70, 2, 0);
    repeat (60) drive(0, 0, 100, 100, 0, 0);
    @(negedge aclk);
    chk("final_exp_queue_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
